// File: rtl/tiny_evr_event_logger.sv
// ---------------------------------------------------------------------------
// TinyEvrEventLogger (module tiny_evr_event_logger)
//
// Decodes the event stream of an EVR transceiver into a {seconds, ticks}
// timestamp and logs a timestamped record of every enabled event code into
// a first-word-fall-through FIFO. Everything runs on evrRxClk.
//
// Parameters
//   SECONDS_WIDTH  width of the seconds field (8..48)
//   TICKS_WIDTH    width of the ticks field (8..48)
//   FIFO_AW        log2 of the FIFO depth
//   LOG_W          derived record width: {[dbus,] code, seconds, ticks}
//
// Ports
//   evrRxClk, evrRxReset        clock, asynchronous active-high reset
//   evrRxWord[15:0]             [7:0] event code, [15:8] distributed bus
//   evrCharIsK[1:0]             bit 0 marks the event byte as a K character
//   cfgWriteEnable/cfgAddress/cfgData   per-code log enable write port
//   ppsMarker                   one-cycle strobe after code 0x7D
//   timestampValid, timestamp   current time and its trust flag
//   logValid/logReady/logData   FWFT read side of the event log
//   logCount                    FIFO occupancy
//   overflowCount/overflowClear saturating count of dropped records
//
// Build option
//   EVR_LOG_DBUS_EN  when defined, the distributed-bus byte of the event
//                    cycle is stored as the top 8 bits of every record.
// ---------------------------------------------------------------------------
module tiny_evr_event_logger #(
    parameter int SECONDS_WIDTH = 32,
    parameter int TICKS_WIDTH   = 32,
    parameter int FIFO_AW       = 5,
`ifdef EVR_LOG_DBUS_EN
    localparam int LOG_W = 16 + SECONDS_WIDTH + TICKS_WIDTH
`else
    localparam int LOG_W = 8 + SECONDS_WIDTH + TICKS_WIDTH
`endif
) (
    input  logic                                evrRxClk,
    input  logic                                evrRxReset,
    input  logic [15:0]                         evrRxWord,
    input  logic [1:0]                          evrCharIsK,
    input  logic                                cfgWriteEnable,
    input  logic [7:0]                          cfgAddress,
    input  logic                                cfgData,
    output logic                                ppsMarker,
    output logic                                timestampValid,
    output logic [SECONDS_WIDTH+TICKS_WIDTH-1:0] timestamp,
    output logic                                logValid,
    input  logic                                logReady,
    output logic [LOG_W-1:0]                    logData,
    output logic [FIFO_AW:0]                    logCount,
    output logic [15:0]                         overflowCount,
    input  logic                                overflowClear
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BCW   = $clog2(SECONDS_WIDTH + 2);
    localparam logic [BCW-1:0] BITS_FULL = BCW'(SECONDS_WIDTH);
    localparam logic [BCW-1:0] BITS_SAT  = BCW'(SECONDS_WIDTH + 1);

    logic [7:0]               eventCode;
    logic                     eventValid;
    logic                     isShift;
    logic                     isMarker;
    logic [SECONDS_WIDTH-1:0] seconds;
    logic [SECONDS_WIDTH-1:0] secondsNext;
    logic [SECONDS_WIDTH-1:0] pendingSeconds;
    logic [TICKS_WIDTH-1:0]   ticks;
    logic [BCW-1:0]           bitCount;
    logic [255:0]             logEnable;
    logic [LOG_W-1:0]         eventRecord;
    logic                     stageValid;
    logic [LOG_W-1:0]         stageRecord;
    logic [LOG_W-1:0]         fifoMem [DEPTH];
    logic [FIFO_AW:0]         wrPtr;
    logic [FIFO_AW:0]         rdPtr;
    logic                     fifoFull;
    logic                     popHead;
    logic                     pushRecord;
    logic                     dropRecord;
    logic                     unusedInputs;

    // Event classification. Code 0x00 and K characters are idle filler and
    // never decode or log. 0x70/0x71 differ only in bit 0, the data bit.
    assign eventCode  = evrRxWord[7:0];
    assign eventValid = !evrCharIsK[0] && (eventCode != 8'h00);
    assign isShift    = eventValid && (eventCode[7:1] == 7'b0111000);
    assign isMarker   = eventValid && (eventCode == 8'h7D);
    assign timestamp  = {seconds, ticks};

    assign unusedInputs = ^{evrCharIsK[1], evrRxWord[15:8]};

    // Seconds value a marker in this cycle would produce. A complete shift
    // sequence wins; otherwise a trusted clock just advances by one second
    // and an untrusted one is left alone.
    always_comb begin
        secondsNext = seconds;
        if (bitCount == BITS_FULL) begin
            secondsNext = pendingSeconds;
        end else if (timestampValid) begin
            secondsNext = seconds + SECONDS_WIDTH'(1);
        end
    end

    // Timestamp engine. Shift codes accumulate the next seconds value MSB
    // first; the marker commits it and restarts ticks. Without a marker the
    // ticks counter runs until its MSB sets and then parks there, at which
    // point the seconds value is no longer trusted.
    always_ff @(posedge evrRxClk or posedge evrRxReset) begin
        if (evrRxReset) begin
            seconds        <= '0;
            ticks          <= '0;
            pendingSeconds <= '0;
            bitCount       <= '0;
            timestampValid <= 1'b0;
            ppsMarker      <= 1'b0;
        end else begin
            ppsMarker <= isMarker;
            if (isShift) begin
                pendingSeconds <= {pendingSeconds[SECONDS_WIDTH-2:0], eventCode[0]};
                if (bitCount != BITS_SAT) begin
                    bitCount <= bitCount + BCW'(1);
                end
            end
            if (isMarker) begin
                ticks    <= '0;
                seconds  <= secondsNext;
                bitCount <= '0;
                if (bitCount == BITS_FULL) begin
                    timestampValid <= 1'b1;
                end
            end else if (!ticks[TICKS_WIDTH-1]) begin
                ticks <= ticks + TICKS_WIDTH'(1);
            end else begin
                timestampValid <= 1'b0;
            end
        end
    end

    // Per-code log enables. Events read the registered value, so a write
    // only affects events from the following cycle on.
    always_ff @(posedge evrRxClk or posedge evrRxReset) begin
        if (evrRxReset) begin
            logEnable <= '0;
        end else if (cfgWriteEnable) begin
            logEnable[cfgAddress] <= cfgData;
        end
    end

    // Record for the current event. A marker records the time it creates,
    // everything else records the time as it stood when the event arrived.
    always_comb begin
        eventRecord = '0;
`ifdef EVR_LOG_DBUS_EN
        if (isMarker) begin
            eventRecord = {evrRxWord[15:8], eventCode, secondsNext, {TICKS_WIDTH{1'b0}}};
        end else begin
            eventRecord = {evrRxWord[15:8], eventCode, seconds, ticks};
        end
`else
        if (isMarker) begin
            eventRecord = {eventCode, secondsNext, {TICKS_WIDTH{1'b0}}};
        end else begin
            eventRecord = {eventCode, seconds, ticks};
        end
`endif
    end

    // One-cycle staging register between decode and the FIFO, so the
    // FIFO write happens on the edge after the event cycle.
    always_ff @(posedge evrRxClk or posedge evrRxReset) begin
        if (evrRxReset) begin
            stageValid  <= 1'b0;
            stageRecord <= '0;
        end else begin
            stageValid  <= eventValid && logEnable[eventCode];
            stageRecord <= eventRecord;
        end
    end

    // FIFO status. Pointers carry one extra wrap bit so occupancy is their
    // difference and "full" is the MSB of that difference. A pop in the same
    // cycle frees the slot a push into a full FIFO needs.
    assign logCount   = wrPtr - rdPtr;
    assign fifoFull   = logCount[FIFO_AW];
    assign logValid   = (logCount != '0);
    assign popHead    = logValid && logReady;
    assign pushRecord = stageValid && (!fifoFull || popHead);
    assign dropRecord = stageValid && fifoFull && !popHead;
    assign logData    = logValid ? fifoMem[rdPtr[FIFO_AW-1:0]] : '0;

    // FIFO storage carries no reset; the pointers decide what is valid.
    always_ff @(posedge evrRxClk) begin
        if (pushRecord) begin
            fifoMem[wrPtr[FIFO_AW-1:0]] <= stageRecord;
        end
    end

    // FIFO pointers; resetting them discards whatever was stored.
    always_ff @(posedge evrRxClk or posedge evrRxReset) begin
        if (evrRxReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (pushRecord) begin
                wrPtr <= wrPtr + (FIFO_AW+1)'(1);
            end
            if (popHead) begin
                rdPtr <= rdPtr + (FIFO_AW+1)'(1);
            end
        end
    end

    // Dropped-record counter. A clear that lands on a drop still counts
    // that drop, so the result is 1 rather than 0.
    always_ff @(posedge evrRxClk or posedge evrRxReset) begin
        if (evrRxReset) begin
            overflowCount <= '0;
        end else if (overflowClear) begin
            overflowCount <= dropRecord ? 16'd1 : 16'd0;
        end else if (dropRecord && (overflowCount != 16'hFFFF)) begin
            overflowCount <= overflowCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_tiny_evr_event_logger.sv
// ---------------------------------------------------------------------------
// Testbench for tiny_evr_event_logger (32-bit seconds, 8-bit ticks, 4-deep
// FIFO). A behavioural model tracks the timestamp, enables and log queue;
// records it expects are queued and a monitor compares them against the FIFO
// head and the status outputs on every falling edge.
// ---------------------------------------------------------------------------
module tb_tiny_evr_event_logger;

    localparam int SW    = 32;
    localparam int TW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
`ifdef EVR_LOG_DBUS_EN
    localparam int LW = 16 + SW + TW;
`else
    localparam int LW = 8 + SW + TW;
`endif

    logic           evrRxClk = 1'b0;
    logic           evrRxReset;
    logic [15:0]    evrRxWord;
    logic [1:0]     evrCharIsK;
    logic           cfgWriteEnable;
    logic [7:0]     cfgAddress;
    logic           cfgData;
    logic           ppsMarker;
    logic           timestampValid;
    logic [SW+TW-1:0] timestamp;
    logic           logValid;
    logic           logReady;
    logic [LW-1:0]  logData;
    logic [AW:0]    logCount;
    logic [15:0]    overflowCount;
    logic           overflowClear;

    int total = 0;
    int bad   = 0;

    logic [31:0]    mSec;
    logic [31:0]    mPending;
    logic [7:0]     mTicks;
    logic           mValid;
    int             mBits;
    logic           mPps;
    logic [255:0]   mEnable;
    logic           mStageValid;
    logic [LW-1:0]  mStageRec;
    int             mCount;
    int             mOv;
    logic [LW-1:0]  expQ[$];

    logic           expPps;
    logic           expValid;
    logic [SW+TW-1:0] expTs;
    int             expCount;
    int             expOv;
    logic           expLogValid;

    tiny_evr_event_logger #(
        .SECONDS_WIDTH(SW),
        .TICKS_WIDTH(TW),
        .FIFO_AW(AW)
    ) dut (
        .evrRxClk(evrRxClk),
        .evrRxReset(evrRxReset),
        .evrRxWord(evrRxWord),
        .evrCharIsK(evrCharIsK),
        .cfgWriteEnable(cfgWriteEnable),
        .cfgAddress(cfgAddress),
        .cfgData(cfgData),
        .ppsMarker(ppsMarker),
        .timestampValid(timestampValid),
        .timestamp(timestamp),
        .logValid(logValid),
        .logReady(logReady),
        .logData(logData),
        .logCount(logCount),
        .overflowCount(overflowCount),
        .overflowClear(overflowClear)
    );

    always #5 evrRxClk = ~evrRxClk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [LW-1:0] makeRec(input logic [7:0] dbus, input logic [7:0] code,
                                              input logic [SW+TW-1:0] ts);
`ifdef EVR_LOG_DBUS_EN
        return {dbus, code, ts};
`else
        return {code, ts} | LW'(dbus & 8'h00);
`endif
    endfunction

    task automatic modelReset();
        mSec = '0; mPending = '0; mTicks = '0; mValid = 1'b0; mBits = 0;
        mPps = 1'b0; mEnable = '0; mStageValid = 1'b0; mStageRec = '0;
        mCount = 0; mOv = 0;
        expQ.delete();
    endtask

    task automatic publish();
        expPps      = mPps;
        expValid    = mValid;
        expTs       = {mSec, mTicks};
        expCount    = mCount;
        expOv       = mOv;
        expLogValid = (mCount > 0);
    endtask

    // Advance the model across one rising edge using the inputs that were
    // present during the cycle that edge closes.
    task automatic modelEdge();
        logic [7:0]       code;
        logic [7:0]       dbus;
        logic             evValid;
        logic             popNow;
        logic             dropNow;
        logic             newStage;
        logic [SW+TW-1:0] ts;
        if (evrRxReset) begin
            modelReset();
            return;
        end
        code    = evrRxWord[7:0];
        dbus    = evrRxWord[15:8];
        evValid = !evrCharIsK[0] && (code != 8'h00);
        popNow  = logReady && (mCount > 0);
        dropNow = 1'b0;
        if (mStageValid) begin
            if (mCount < DEPTH || popNow) begin
                expQ.push_back(mStageRec);
                mCount++;
            end else begin
                dropNow = 1'b1;
            end
        end
        if (popNow) mCount--;
        if (overflowClear) mOv = dropNow ? 1 : 0;
        else if (dropNow && mOv < 65535) mOv++;
        ts       = {mSec, mTicks};
        newStage = evValid && mEnable[code];
        mPps     = evValid && (code == 8'h7D);
        if (mPps) begin
            if (mBits == SW) begin
                mSec   = mPending;
                mValid = 1'b1;
            end else if (mValid) begin
                mSec = mSec + 32'd1;
            end
            mTicks = 8'h00;
            mBits  = 0;
            ts     = {mSec, 8'h00};
        end else begin
            if (evValid && (code == 8'h70 || code == 8'h71)) begin
                mPending = (mPending << 1) | 32'(code[0]);
                if (mBits < SW + 1) mBits++;
            end
            if (mTicks < 8'h80) mTicks = mTicks + 8'd1;
            else mValid = 1'b0;
        end
        if (cfgWriteEnable) mEnable[cfgAddress] = cfgData;
        mStageValid = newStage;
        mStageRec   = makeRec(dbus, code, ts);
    endtask

    task automatic applyStimulus(input logic [7:0] code, input logic [7:0] dbus, input logic isK,
                                 input logic we, input logic [7:0] addr, input logic data,
                                 input logic ready, input logic clear);
        @(posedge evrRxClk);
        #1;
        modelEdge();
        evrRxReset     = 1'b0;
        evrRxWord      = {dbus, code};
        evrCharIsK     = {1'b0, isK};
        cfgWriteEnable = we;
        cfgAddress     = addr;
        cfgData        = data;
        logReady       = ready;
        overflowClear  = clear;
        publish();
    endtask

    task automatic applyReset();
        @(posedge evrRxClk);
        #1;
        modelEdge();
        evrRxReset = 1'b1;
        modelReset();
        publish();
    endtask

    task automatic sendEvent(input logic [7:0] code, input logic ready);
        applyStimulus(code, 8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0, ready, 1'b0);
    endtask

    task automatic idle(input logic ready, input logic clear);
        applyStimulus(8'h00, 8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0, ready, clear);
    endtask

    task automatic loadSeconds(input logic [31:0] value, input int nBits, input logic ready);
        for (int i = nBits - 1; i >= 0; i--) begin
            sendEvent(value[i] ? 8'h71 : 8'h70, ready);
        end
        sendEvent(8'h7D, ready);
    endtask

    task automatic randomCycle(input int readyPct);
        int       r;
        logic [7:0] code;
        logic [7:0] addr;
        r = $urandom_range(0, 99);
        if (r < 20)      code = 8'h2A;
        else if (r < 30) code = 8'h2B;
        else if (r < 45) code = ($urandom_range(0, 1) == 1) ? 8'h71 : 8'h70;
        else if (r < 48) code = 8'h7D;
        else if (r < 60) code = 8'h00;
        else             code = 8'($urandom);
        case ($urandom_range(0, 4))
            0: addr = 8'h2A;
            1: addr = 8'h2B;
            2: addr = 8'h7D;
            3: addr = 8'h71;
            default: addr = 8'($urandom);
        endcase
        applyStimulus(code, 8'($urandom), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 15) == 0), addr, 1'($urandom),
                      ($urandom_range(0, 99) < readyPct), ($urandom_range(0, 63) == 0));
    endtask

    // Monitor: compares status outputs every cycle and the FIFO head against
    // the scoreboard queue; the head is retired when the model says it pops.
    initial begin
        forever begin
            @(negedge evrRxClk);
            checkOutput("ppsMarker", 64'(ppsMarker), 64'(expPps));
            checkOutput("timestampValid", 64'(timestampValid), 64'(expValid));
            checkOutput("timestamp", 64'(timestamp), 64'(expTs));
            checkOutput("logValid", 64'(logValid), 64'(expLogValid));
            checkOutput("logCount", 64'(logCount), 64'(expCount));
            checkOutput("overflowCount", 64'(overflowCount), 64'(expOv));
            if (expLogValid && expQ.size() > 0) begin
                checkOutput("logData", 64'(logData), 64'(expQ[0]));
                if (logReady) void'(expQ.pop_front());
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        evrRxReset     = 1'b1;
        evrRxWord      = '0;
        evrCharIsK     = '0;
        cfgWriteEnable = 1'b0;
        cfgAddress     = '0;
        cfgData        = 1'b0;
        logReady       = 1'b0;
        overflowClear  = 1'b0;
        modelReset();
        publish();

        @(negedge evrRxClk);
        checkOutput("reset timestamp", 64'(timestamp), 64'h0);
        checkOutput("reset timestampValid", 64'(timestampValid), 64'h0);
        checkOutput("reset logValid", 64'(logValid), 64'h0);
        checkOutput("reset logData", 64'(logData), 64'h0);
        checkOutput("reset logCount", 64'(logCount), 64'h0);
        checkOutput("reset overflowCount", 64'(overflowCount), 64'h0);

        idle(1'b0, 1'b0);
        loadSeconds(32'h12345678, 32, 1'b0);
        idle(1'b0, 1'b0);
        @(negedge evrRxClk);
        checkOutput("load timestamp", 64'(timestamp), 64'h12345678_00);
        checkOutput("load timestampValid", 64'(timestampValid), 64'h1);
        checkOutput("load ppsMarker", 64'(ppsMarker), 64'h1);
        idle(1'b0, 1'b0);
        @(negedge evrRxClk);
        checkOutput("ticks one", 64'(timestamp), 64'h12345678_01);
        checkOutput("pps one cycle", 64'(ppsMarker), 64'h0);

        loadSeconds(32'h0000_0F0F, 31, 1'b0);
        idle(1'b0, 1'b0);
        @(negedge evrRxClk);
        checkOutput("short load increments", 64'(timestamp), 64'h12345679_00);
        checkOutput("short load valid", 64'(timestampValid), 64'h1);

        repeat (140) idle(1'b0, 1'b0);
        @(negedge evrRxClk);
        checkOutput("ticks frozen", 64'(timestamp), 64'h12345679_80);
        checkOutput("frozen invalid", 64'(timestampValid), 64'h0);

        applyReset();
        loadSeconds(32'h12345678, 31, 1'b0);
        idle(1'b0, 1'b0);
        @(negedge evrRxClk);
        checkOutput("invalid short load", 64'(timestampValid), 64'h0);
        checkOutput("invalid short ts", 64'(timestamp), 64'h0);

        applyReset();
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 8'h2A, 1'b1, 1'b0, 1'b0);
        sendEvent(8'h2A, 1'b0);
        sendEvent(8'h2B, 1'b0);
        sendEvent(8'h2A, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        @(negedge evrRxClk);
        checkOutput("filtered logCount", 64'(logCount), 64'h2);
        checkOutput("filtered head code", 64'(logData[SW+TW+7:SW+TW]), 64'h2A);

        applyReset();
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 8'h2A, 1'b1, 1'b0, 1'b0);
        repeat (5) sendEvent(8'h2A, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        @(negedge evrRxClk);
        checkOutput("full logCount", 64'(logCount), 64'h4);
        checkOutput("first overflow", 64'(overflowCount), 64'h1);
        sendEvent(8'h2A, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        @(negedge evrRxClk);
        checkOutput("push on pop logCount", 64'(logCount), 64'h4);
        checkOutput("push on pop overflow", 64'(overflowCount), 64'h1);
        sendEvent(8'h2A, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        @(negedge evrRxClk);
        checkOutput("second overflow", 64'(overflowCount), 64'h2);
        sendEvent(8'h2A, 1'b0);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        @(negedge evrRxClk);
        checkOutput("clear with drop", 64'(overflowCount), 64'h1);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        @(negedge evrRxClk);
        checkOutput("plain clear", 64'(overflowCount), 64'h0);

        repeat (6) idle(1'b1, 1'b0);
        applyStimulus(8'h2A, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        @(negedge evrRxClk);
`ifdef EVR_LOG_DBUS_EN
        checkOutput("dbus byte", 64'(logData[LW-1:LW-8]), 64'hA5);
`else
        checkOutput("record code", 64'(logData[LW-1:LW-8]), 64'h2A);
`endif

        for (int blk = 0; blk < 5; blk++) begin
            if (blk == 2) applyReset();
            applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 8'h2A, 1'b1, 1'b1, 1'b0);
            loadSeconds($urandom, 32, 1'($urandom));
            for (int c = 0; c < 300; c++) begin
                randomCycle((blk % 2 == 0) ? 30 : 85);
            end
        end
        repeat (10) idle(1'b1, 1'b0);
        @(negedge evrRxClk);
        checkOutput("drained logCount", 64'(logCount), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
